rst_sequencer: RTL

- Sits directly downstream of the clock manager, on its 100 MHz output clock.
- Qualifies the asynchronous MMCM lock flag and releases synchronous resets in a fixed order: system core first, then peripherals.
- Re-asserts both resets on loss of lock and counts lock-loss events.
- Generates a 1 ms clock-enable tick for the rest of the design.

---
 rtl/rst_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/rst_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rst_sequencer: lock-qualified ordered reset release plus a 1 ms tick.
// Revision: 1.0
// ---------------------------------------------------------------------------
module rst_sequencer #(
  parameter int LOCK_STABLE_CYC   = 1000,
  parameter int SYS_TO_PERIPH_CYC = 100,
  parameter int TICK_DIV          = 100000,
  parameter int LOST_CNT_W        = 8
) (
  input  logic                  iclk_100MHz,
  input  logic                  irst,
  input  logic                  ilocked,
  output logic                  orst_sys,
  output logic                  orst_periph,
  output logic                  oready,
  output logic                  otick_1ms,
  output logic [LOST_CNT_W-1:0] olock_lost_cnt,
  output logic [2:0]            ostate
);

  localparam int STAB_W = (LOCK_STABLE_CYC > 1) ? $clog2(LOCK_STABLE_CYC) : 1;
  localparam int DLY_W  = (SYS_TO_PERIPH_CYC > 1) ? $clog2(SYS_TO_PERIPH_CYC) : 1;
  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYC - 1);
  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(SYS_TO_PERIPH_CYC - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [LOST_CNT_W-1:0] LOST_MAX = {LOST_CNT_W{1'b1}};

  localparam logic [2:0] WAIT_LOCK = 3'd0;
  localparam logic [2:0] STABILIZE = 3'd1;
  localparam logic [2:0] SYS_UP    = 3'd2;
  localparam logic [2:0] RUN       = 3'd3;
  localparam logic [2:0] LOST      = 3'd4;

  logic                  lk_meta;
  logic                  lk_s;
  logic [2:0]            state;
  logic [2:0]            next_state;
  logic [STAB_W-1:0]     stab_cnt;
  logic [DLY_W-1:0]      dly_cnt;
  logic [DIV_W-1:0]      div_cnt;
  logic [LOST_CNT_W-1:0] lost_cnt;
  logic                  div_run;

  // ilocked comes from another clock domain; only lk_s is used past here
  always_ff @(posedge iclk_100MHz) begin
    if (irst) begin
      lk_meta <= 1'b0;
      lk_s    <= 1'b0;
    end else begin
      lk_meta <= ilocked;
      lk_s    <= lk_meta;
    end
  end

  always_ff @(posedge iclk_100MHz) begin
    if (irst) begin
      state <= WAIT_LOCK;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      WAIT_LOCK: begin
        if (lk_s) next_state = STABILIZE;
      end
      STABILIZE: begin
        // a dropout here is a glitch before release, not a counted loss
        if (!lk_s)                     next_state = WAIT_LOCK;
        else if (stab_cnt == STAB_LAST) next_state = SYS_UP;
      end
      SYS_UP: begin
        if (!lk_s)                   next_state = LOST;
        else if (dly_cnt == DLY_LAST) next_state = RUN;
      end
      RUN: begin
        if (!lk_s) next_state = LOST;
      end
      LOST:    next_state = WAIT_LOCK;
      default: next_state = WAIT_LOCK;
    endcase
  end

  assign div_run = (state == SYS_UP) || (state == RUN);

  always_ff @(posedge iclk_100MHz) begin
    if (irst) begin
      stab_cnt <= '0;
      dly_cnt  <= '0;
      div_cnt  <= '0;
      lost_cnt <= '0;
    end else begin
      if (state == STABILIZE && next_state == STABILIZE) stab_cnt <= stab_cnt + 1'b1;
      else                                               stab_cnt <= '0;

      if (state == SYS_UP && next_state == SYS_UP) dly_cnt <= dly_cnt + 1'b1;
      else                                         dly_cnt <= '0;

      // divider only survives SYS_UP/RUN-to-SYS_UP/RUN edges, so leaving clears it
      if (div_run && (next_state == SYS_UP || next_state == RUN)) begin
        if (div_cnt == DIV_LAST) div_cnt <= '0;
        else                     div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
      end

      if (state != LOST && next_state == LOST && lost_cnt != LOST_MAX)
        lost_cnt <= lost_cnt + 1'b1;
    end
  end

  always_comb begin
    orst_sys    = 1'b1;
    orst_periph = 1'b1;
    oready      = 1'b0;
    case (state)
      SYS_UP: begin
        orst_sys = 1'b0;
      end
      RUN: begin
        orst_sys    = 1'b0;
        orst_periph = 1'b0;
        oready      = 1'b1;
      end
      default: begin
        orst_sys    = 1'b1;
        orst_periph = 1'b1;
        oready      = 1'b0;
      end
    endcase
    otick_1ms      = div_run && (div_cnt == DIV_LAST);
    olock_lost_cnt = lost_cnt;
    ostate         = state;
  end

endmodule
`default_nettype wire
